router_fifo: RTL and testbench
==============================

// Module: router_fifo
// PURPOSE
//  One of three identical per-destination output FIFOs of the 1x3 router. Downstream of router_sync:
//  - writes when its bit of router_sync's write_enb is high;
//  - its soft_reset_N clears it after a read timeout;
//  - returns empty/full, which router_sync turns into vld_out_N and fifo_full.
//  Tags header bytes and tracks the packet length so data_out returns to 0 between packets.
// PARAMETERS
//  WIDTH   8   data byte width
//  DEPTH   16  number of entries (power of two)
//  ADDR_W  4   log2(DEPTH); internal pointers are ADDR_W+1 bits
// PORTS
//  clk         in   1      rising-edge clock, only clock
//  reset       in   1      synchronous, active-high hard reset
//  soft_reset  in   1      synchronous, active-high flush (from router_sync soft_reset_N)
//  write_enb   in   1      write request (one bit of router_sync write_enb)
//  read_enb    in   1      read request from destination client
//  lfd_state   in   1      high with write_enb: current byte is a packet header
//  data_in     in   WIDTH  byte to store
//  data_out    out  WIDTH  registered read data
//  empty       out  1      no entries stored
//  full        out  1      DEPTH entries stored
// BEHAVIOUR
//  - Storage: DEPTH entries of WIDTH+1 bits, {hdr_flag, byte}; hdr_flag = lfd_state at write time.
//  - Pointers: wr_ptr, rd_ptr are ADDR_W+1 bits and wrap modulo 2*DEPTH.
//    - empty = (wr_ptr == rd_ptr)
//    - full  = MSBs differ and the low ADDR_W bits are equal
//    - empty/full are decoded combinationally from registered pointers only.
//  - Write accepted iff write_enb && !full, using the current-cycle full.
//    On accept: mem[wr_ptr] <= {lfd_state, data_in}; wr_ptr += 1. Write while full is dropped silently.
//  - Read accepted iff read_enb && !empty. On accept: data_out <= byte of mem[rd_ptr]; rd_ptr += 1.
//    Latency 1: byte visible on data_out the cycle after read_enb is sampled.
//  - Read while empty: no pointer change; data_out is handled by the pkt_cnt rule below.
//  - Simultaneous write and read:
//    - both are evaluated on pre-edge flags;
//    - when full, the read is taken and the write is dropped;
//    - when empty, the write is taken and the read is ignored;
//    - otherwise both are taken and occupancy is unchanged.
//  - pkt_cnt, 7 bits, counts bytes remaining in the current packet:
//    - accepted read of an entry with hdr_flag=1: pkt_cnt <= byte[7:2] + 1 (payload + parity);
//    - accepted read of a non-header entry with pkt_cnt != 0: pkt_cnt <= pkt_cnt - 1;
//    - accepted read of a non-header entry with pkt_cnt == 0: byte still output, pkt_cnt stays 0.
//  - data_out clear rule: if pkt_cnt == 0 and no read is accepted, data_out <= 0.
//    data_out therefore reads 0 one cycle after the parity byte is consumed.
//  - Reset/flush priority: reset > soft_reset > read/write.
//    Either reset clears wr_ptr, rd_ptr, pkt_cnt and data_out to 0; memory contents are not cleared.
//    A write or read in the same cycle as a reset or soft_reset is discarded.
//  - Reset values: data_out = 0, empty = 1, full = 0.
//  - soft_reset mid-packet abandons the remainder.
//    The next accepted write after the flush lands at entry 0.
// TESTING
//  1 Assert reset 2 cycles -> empty=1, full=0, data_out=8'h00. Repeat with soft_reset alone -> same result.
//  2 Write 16 bytes 8'h10..8'h1F, then a 17th byte 8'hAA.
//    -> full=1 after the 16th write; 8'hAA dropped; 16 reads return 10..1F then empty=1.
//  3 Write header 8'h0D (lfd_state=1), then 8'h01,8'h02,8'h03 and parity 8'h0F; read continuously.
//    -> data_out shows 0D,01,02,03,0F on consecutive cycles, then 8'h00; pkt_cnt goes 4,3,2,1,0.
//  4 Fill to full, then assert write_enb and read_enb together with data_in=8'h55.
//    -> oldest byte read out, 8'h55 not stored, full=0 next cycle.
//  5 Stream 40 bytes with a read 2 cycles behind each write.
//    -> pointers wrap past 31->0; every byte returns in order; full never asserts.
//  6 Write 3 bytes of a 5-byte packet, read 1, pulse soft_reset.
//    -> empty=1, data_out=8'h00 next cycle; the next write/read pair returns the new byte.

Source files
------------

// File: rtl/router_fifo_if.sv
// Byte-stream handshake between router_sync/destination client and one router output FIFO.
// master drives write/read requests and write data; slave (the FIFO) returns data and status.
interface router_fifo_if #(
  parameter int WIDTH = 8
);
  logic             write_enb;
  logic             read_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             full;

  modport master (
    output write_enb, read_enb, lfd_state, data_in,
    input  data_out, empty, full
  );

  modport slave (
    input  write_enb, read_enb, lfd_state, data_in,
    output data_out, empty, full
  );
endinterface

// File: rtl/router_fifo.sv
// Per-destination router output FIFO: header-tagged entries, 1-cycle registered read, data_out zeroed between packets.
// Writes while full are dropped; reads while empty are ignored; empty/full decode straight from the pointers.
module router_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               soft_reset,
  router_fifo_if.slave       bus
);

  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

  logic [WIDTH:0]   mem [DEPTH];
  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic [6:0]       pkt_cnt;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH:0]   rd_ent;
  logic             empty;
  logic             full;
  logic             wr_acc;
  logic             rd_acc;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                  (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign wr_acc = bus.write_enb && !full;
  assign rd_acc = bus.read_enb && !empty;
  assign rd_ent = mem[rd_ptr[ADDR_W-1:0]];

  assign bus.data_out = dout_q;
  assign bus.empty    = empty;
  assign bus.full     = full;

  // Storage is never cleared; only the pointers are, so stale entries are unreachable.
  always_ff @(posedge clk) begin
    if (!reset && !soft_reset && wr_acc) begin
      mem[wr_ptr[ADDR_W-1:0]] <= {bus.lfd_state, bus.data_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || soft_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pkt_cnt <= '0;
      dout_q  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        dout_q <= rd_ent[WIDTH-1:0];
        // Header length field counts payload bytes; the +1 covers the trailing parity byte.
        if (rd_ent[WIDTH]) begin
          pkt_cnt <= 7'(rd_ent[WIDTH-1:2]) + 7'd1;
        end else if (pkt_cnt != 7'd0) begin
          pkt_cnt <= pkt_cnt - 7'd1;
        end
      end else if (pkt_cnt == 7'd0) begin
        dout_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Directed plus random checks of router_fifo against a queue-based packet model.
module tb_router_fifo;

  logic clk = 1'b0;
  logic reset;
  logic soft_reset;
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [8:0] q[$];
  logic [7:0] m_dout;
  int         m_cnt;
  int         m_wr;
  int         m_rd;

  router_fifo_if #(.WIDTH(8)) bus ();

  router_fifo #(.WIDTH(8), .DEPTH(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .soft_reset (soft_reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clock(input logic rst, input logic sr, input logic we,
                             input logic re, input logic lfd, input logic [7:0] din);
    logic       was_full;
    logic       was_empty;
    logic [8:0] e;
    if (rst || sr) begin
      q.delete();
      m_dout = 8'h00;
      m_cnt  = 0;
      m_wr   = 0;
      m_rd   = 0;
    end else begin
      was_full  = (q.size() == 16);
      was_empty = (q.size() == 0);
      if (re && !was_empty) begin
        e      = q.pop_front();
        m_dout = e[7:0];
        m_rd++;
        if (e[8]) m_cnt = int'(e[7:2]) + 1;
        else if (m_cnt > 0) m_cnt--;
      end else if (m_cnt == 0) begin
        m_dout = 8'h00;
      end
      if (we && !was_full) begin
        q.push_back({lfd, din});
        m_wr++;
      end
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic sr, input logic we,
                      input logic re, input logic lfd, input logic [7:0] din);
    reset         = rst;
    soft_reset    = sr;
    bus.write_enb = we;
    bus.read_enb  = re;
    bus.lfd_state = lfd;
    bus.data_in   = din;
    @(posedge clk);
    model_clock(rst, sr, we, re, lfd, din);
    #1;
    chk({tag, ".data_out"}, 32'(bus.data_out), 32'(m_dout));
    chk({tag, ".empty"},    32'(bus.empty),    32'(q.size() == 0));
    chk({tag, ".full"},     32'(bus.full),     32'(q.size() == 16));
    chk({tag, ".pkt_cnt"},  32'(dut.pkt_cnt),  32'(m_cnt));
    chk({tag, ".wr_ptr"},   32'(dut.wr_ptr),   32'(m_wr % 32));
    chk({tag, ".rd_ptr"},   32'(dut.rd_ptr),   32'(m_rd % 32));
  endtask

  initial begin
    logic [7:0] pkt [5];
    reset = 1'b1; soft_reset = 1'b0;
    bus.write_enb = 1'b0; bus.read_enb = 1'b0; bus.lfd_state = 1'b0; bus.data_in = 8'h00;
    q.delete(); m_dout = 8'h00; m_cnt = 0; m_wr = 0; m_rd = 0;

    // 1: hard reset, then soft reset on its own after storing a byte
    step("rst",  1, 0, 0, 0, 0, 8'h00);
    step("rst",  1, 0, 0, 0, 0, 8'h00);
    step("pre",  0, 0, 1, 0, 0, 8'h3C);
    step("srst", 0, 1, 0, 0, 0, 8'h00);
    step("srst", 0, 1, 0, 0, 0, 8'h00);
    chk("srst_empty_const", 32'(bus.empty), 32'd1);
    chk("srst_dout_const",  32'(bus.data_out), 32'd0);

    // 2: fill with 10..1F, overflow byte AA dropped, drain
    for (int i = 0; i < 16; i++) step("fill", 0, 0, 1, 0, 0, 8'(8'h10 + i));
    chk("full_after_16", 32'(bus.full), 32'd1);
    step("ovf", 0, 0, 1, 0, 0, 8'hAA);
    for (int i = 0; i < 16; i++) begin
      step("drain", 0, 0, 0, 1, 0, 8'h00);
      chk("drain_byte", 32'(bus.data_out), 32'(8'h10 + i));
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);
    step("idle", 0, 0, 0, 0, 0, 8'h00);

    // 3: header 0D (length 3) then three payload bytes and parity, continuous read
    pkt[0] = 8'h0D; pkt[1] = 8'h01; pkt[2] = 8'h02; pkt[3] = 8'h03; pkt[4] = 8'h0F;
    for (int i = 0; i < 5; i++) step("pkt_wr", 0, 0, 1, 0, (i == 0), pkt[i]);
    for (int i = 0; i < 5; i++) begin
      step("pkt_rd", 0, 0, 0, 1, 0, 8'h00);
      chk("pkt_byte", 32'(bus.data_out), 32'(pkt[i]));
      chk("pkt_cnt_seq", 32'(dut.pkt_cnt), 32'(4 - i));
    end
    step("pkt_end", 0, 0, 0, 0, 0, 8'h00);
    chk("pkt_end_zero", 32'(bus.data_out), 32'd0);

    // 4: simultaneous write/read when full keeps the read, drops the write
    for (int i = 0; i < 16; i++) step("fill2", 0, 0, 1, 0, 0, 8'(8'hA0 + i));
    step("both_full", 0, 0, 1, 1, 0, 8'h55);
    chk("both_full_dout", 32'(bus.data_out), 32'hA0);
    chk("both_full_nf",   32'(bus.full), 32'd0);
    for (int i = 0; i < 16; i++) step("drain2", 0, 0, 0, 1, 0, 8'h00);
    chk("no_55", 32'(bus.data_out), 32'h00);

    // 5: stream 40 bytes with reads trailing by two cycles; pointers wrap
    for (int i = 0; i < 42; i++)
      step("stream", 0, 0, (i < 40), (i >= 2), 0, 8'(8'h40 + i));
    step("stream_idle", 0, 0, 0, 0, 0, 8'h00);

    // 6: soft reset abandons a partly read packet
    step("p6", 0, 0, 1, 0, 1, 8'h0C);
    step("p6", 0, 0, 1, 0, 0, 8'h21);
    step("p6", 0, 0, 1, 0, 0, 8'h22);
    step("p6_rd", 0, 0, 0, 1, 0, 8'h00);
    step("p6_sr", 0, 1, 0, 0, 0, 8'h00);
    chk("p6_dout_zero", 32'(bus.data_out), 32'd0);
    step("p6_wr", 0, 0, 1, 0, 0, 8'h77);
    chk("p6_wr_ptr", 32'(dut.wr_ptr), 32'd1);
    step("p6_rd2", 0, 0, 0, 1, 0, 8'h00);
    chk("p6_new_byte", 32'(bus.data_out), 32'h77);
    step("p6_idle", 0, 0, 0, 0, 0, 8'h00);

    // Random traffic: write-heavy then read-heavy phases, occasional header/flush/reset
    for (int i = 0; i < 600; i++) begin
      logic we, re, lfd, sr, rst;
      if ((i / 100) % 2 == 0) begin
        we = ($urandom_range(0, 3) != 0);
        re = ($urandom_range(0, 3) == 0);
      end else begin
        we = ($urandom_range(0, 3) == 0);
        re = ($urandom_range(0, 3) != 0);
      end
      lfd = ($urandom_range(0, 7) == 0);
      sr  = ($urandom_range(0, 79) == 0);
      rst = ($urandom_range(0, 249) == 0);
      step("rand", rst, sr, we, re, lfd, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
